uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Memory-mapped UART transmitter peripheral for the RISC-V pipeline SoC.
- It is the transmit-side counterpart of the core's UART receive path and drives the top-level uart_tx pin.
- The CPU store path pushes bytes into an internal FIFO.
- A baud-timed FSM serialises each byte as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bits/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be ≥2).
- FIFO_DEPTH, 8: transmit FIFO entries. Must be a power of 2, ≥2.
- DATA_BITS, 8: data bits per frame. Fixed at 8 for this revision.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  push request from CPU store decode; sampled on rising clk.
- wr_data  input  8  byte to push.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- busy  output  1  FSM not in IDLE (frame in progress).
- overflow  output  1  sticky: a push was attempted while full.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- uart_tx  output  1  serial line, registered; idle high.

Behaviour:
- Reset (reset=0, asynchronous):
  - uart_tx=1, busy=0, tx_done=0, overflow=0, empty=1, full=0.
  - FIFO pointers and count=0, FSM=IDLE, baud counter=0, bit index=0.
  - Reset asserted mid-frame aborts the frame immediately; line returns high; FIFO contents discarded.
- FIFO push:
  - When wr_en=1 and full=0, wr_data is written and count increments on that edge.
  - When wr_en=1 and full=1, the byte is dropped and overflow is set. A same-cycle pop does not admit the write.
- Overflow flag:
  - clr_ovf=1 clears overflow on the next edge.
  - clr_ovf wins over a simultaneous overflow event only if no dropped push occurs in that cycle. If both occur, overflow stays 1.
- FIFO pointers: wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx=1.
  - If empty=0, load head byte into shift register, pop FIFO, clear baud counter, go to START.
  - Latency: push into empty FIFO at edge N; uart_tx falls after edge N+1.
- START:
  - uart_tx=0 for CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1. On terminal count, reset the counter, set bit index=0, go to DATA.
- DATA:
  - uart_tx = shift_reg[0] for CLKS_PER_BIT cycles per bit.
  - On terminal count, shift right and increment bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - uart_tx=1 for CLKS_PER_BIT cycles.
  - On terminal count, pulse tx_done for 1 cycle.
  - If empty=0, load and pop the next byte and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from start-bit falling edge to end of stop bit.
- busy=1 in START, DATA and STOP, including across back-to-back frames.
- Pushes during a frame are legal. A frame in flight is never altered by FIFO activity.
- full and empty are combinational from count.
- uart_tx, tx_done and busy are registered.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (2-bit localparams S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3).
  - The CLKS_PER_BIT computation function.
  - The 8N1 frame constants (start=0, stop=1, 8 data bits).
- One sub-module, sync_fifo:
  - Parameterised width and depth; single clock, async active-low reset.
  - Ports: push, pop, din, dout (head, combinational read), full, empty, count.
- uart_tx_fifo instantiates sync_fifo and contains the baud counter and FSM.
- sync_fifo is reusable by the receive path.

Test Plan:
- Reset with CLK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10) -> uart_tx=1, empty=1, busy=0, overflow=0 for 50 idle cycles.
- Push 0xA5 once -> uart_tx low 10 cycles starting edge N+1. Then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. tx_done pulses once at cycle 100 of the frame; busy falls with it.
- Push 0x00, 0xFF, 0x55 on consecutive cycles -> three frames back-to-back, 300 cycles total with no idle gap. busy stays 1 throughout; tx_done pulses 3 times; empty=1 at end.
- Push 10 bytes (0x01..0x0A) in consecutive cycles with FIFO_DEPTH=8 -> first byte pops after 1 cycle, so 0x01..0x09 accepted and 0x0A dropped. overflow=1 and stays set until clr_ovf pulse, then 0. Line carries 0x01..0x09 only.
- Assert reset during DATA bit 3 of 0x3C with 2 more bytes queued -> uart_tx=1 immediately. After release: empty=1, busy=0, no further frames.
- wr_en with full=1 and clr_ovf=1 same cycle -> overflow remains 1. The next clr_ovf alone clears it.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit/receive paths.
//   - FSM state encoding (S_IDLE/S_START/S_DATA/S_STOP) and the matching enum
//   - 8N1 frame constants
//   - calc_clks_per_bit(): clock cycles per serial bit
package uart_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_STOP  = S_STOP
  } tx_state_t;

  // 8N1 framing
  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

  // Integer division; callers must keep the result >= 2.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, reusable by both UART directions.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, din         write request and data; ignored while full
//   pop               read request; ignored while empty
//   dout              head entry, combinational read (valid while !empty)
//   full, empty       combinational from count
//   count             number of stored entries (0..DEPTH)
// Handshake: a push is accepted on a rising edge iff push=1 and full=0 at that
// edge; a pop is accepted iff pop=1 and empty=0. A simultaneous pop never
// makes room for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a transmit FIFO.
// Bytes pushed by the CPU store path are serialised as 8N1 frames
// (start 0, 8 data bits LSB first, stop 1) at CLK_FREQ/BAUD_RATE clocks/bit.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   wr_en, wr_data    push request (accepted when !full, else dropped)
//   clr_ovf           clears the sticky overflow flag (a same-cycle drop wins)
//   full, empty       FIFO status, combinational from the FIFO count
//   busy              frame in progress (registered)
//   overflow          sticky: push attempted while full
//   tx_done           one-cycle pulse at the end of each stop bit (registered)
//   uart_tx           serial line, registered, idle high
//   state_dbg         current FSM state encoding
//   fifo_level        current FIFO count
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_BITS  = FRAME_DATA_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          clr_ovf,
  output logic                          full,
  output logic                          empty,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx_done,
  output logic                          uart_tx,
  output logic [1:0]                    state_dbg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB   = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 baud_tick;
  logic                 load;
  logic                 drop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_en),
    .pop   (load),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_level)
  );

  assign baud_tick = (baud_cnt == CNT_W'(CPB - 1));
  // The next byte is taken either from IDLE or at the very end of a stop bit,
  // so back-to-back frames have no idle gap.
  assign load      = !empty && ((state == ST_IDLE) || (state == ST_STOP && baud_tick));
  assign drop      = wr_en && full;
  assign state_dbg = state;

  // Overflow: a dropped push in the same cycle beats clr_ovf.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= STOP_BIT;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          uart_tx <= STOP_BIT;
          if (load) begin
            shift_reg <= fifo_dout;
            baud_cnt  <= '0;
            uart_tx   <= START_BIT;
            busy      <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift_reg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              uart_tx <= STOP_BIT;
              state   <= ST_STOP;
            end else begin
              // Next bit is the one about to be shifted into position 0.
              uart_tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            tx_done  <= 1'b1;
            if (load) begin
              shift_reg <= fifo_dout;
              uart_tx   <= START_BIT;
              state     <= ST_START;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
